// File: rtl/ysyx_23060191_ctrl_if.sv
// Instruction-fetch handshake between the NPC sequencer (master) and the fetch unit (slave).
interface ysyx_23060191_ctrl_if #(
  parameter int CPU_WIDTH = 32
);
  logic                 ifu_req_valid;
  logic                 ifu_req_ready;
  logic [CPU_WIDTH-1:0] ifu_addr;
  logic                 ifu_rsp_valid;
  logic [CPU_WIDTH-1:0] ifu_rsp_inst;

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_inst
  );

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_inst
  );
endinterface

// File: rtl/ysyx_23060191_ctrl.sv
// NPC multi-cycle sequencer: FETCH -> WAIT -> DECODE -> EXEC -> WB, owning PC, IR,
// GPR write enable and the retired-instruction counter; halts permanently on faults.
module ysyx_23060191_ctrl #(
  parameter int                   CPU_WIDTH   = 32,
  parameter logic [CPU_WIDTH-1:0] RESET_PC    = 32'h8000_0000,
  parameter int                   EXU_TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_23060191_ctrl_if.master        ifu,
  output logic [CPU_WIDTH-1:0]        inst_to_dec,
  output logic                        dec_valid,
  input  logic                        is_ebreak,
  input  logic                        is_illegal,
  input  logic [4:0]                  rd_addr,
  output logic                        exu_start,
  input  logic                        exu_done,
  input  logic [CPU_WIDTH-1:0]        next_pc,
  output logic                        gpr_wen,
  output logic [CPU_WIDTH-1:0]        pc,
  output logic                        halt,
  output logic [1:0]                  halt_code,
  output logic [63:0]                 instret
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    HC_EBREAK  = 2'b00,
    HC_ILLEGAL = 2'b01,
    HC_TIMEOUT = 2'b10,
    HC_MISALGN = 2'b11
  } halt_code_e;

  localparam logic [7:0] TIMEOUT_LAST = 8'(EXU_TIMEOUT - 1);

  state_e     state;
  logic       req_valid;
  logic [7:0] exu_cnt;

  // The fetch address is the architectural PC, which only moves in WB, so it is
  // naturally stable for the whole FETCH handshake.
  assign ifu.ifu_req_valid = req_valid;
  assign ifu.ifu_addr      = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      inst_to_dec <= '0;
      instret     <= '0;
      halt        <= 1'b0;
      halt_code   <= HC_EBREAK;
      req_valid   <= 1'b0;
      dec_valid   <= 1'b0;
      exu_start   <= 1'b0;
      gpr_wen     <= 1'b0;
      exu_cnt     <= '0;
    end else begin
      // NOTE: every registered pulse is defaulted low here and raised only on the
      // transition into its state; non-blocking keeps all updates edge-aligned.
      dec_valid <= 1'b0;
      exu_start <= 1'b0;
      gpr_wen   <= 1'b0;

      unique case (state)
        S_FETCH: begin
          if (req_valid && ifu.ifu_req_ready) begin
            req_valid <= 1'b0;
            state     <= S_WAIT;
          end else begin
            req_valid <= 1'b1;
          end
        end

        S_WAIT: begin
          if (ifu.ifu_rsp_valid) begin
            inst_to_dec <= ifu.ifu_rsp_inst;
            dec_valid   <= 1'b1;
            state       <= S_DECODE;
          end
        end

        S_DECODE: begin
          if (is_illegal) begin
            halt      <= 1'b1;
            halt_code <= HC_ILLEGAL;
            state     <= S_HALT;
          end else if (is_ebreak) begin
            // ebreak counts as retired; an illegal opcode does not.
            halt      <= 1'b1;
            halt_code <= HC_EBREAK;
            instret   <= instret + 64'd1;
            state     <= S_HALT;
          end else begin
            exu_start <= 1'b1;
            exu_cnt   <= '0;
            state     <= S_EXEC;
          end
        end

        S_EXEC: begin
          if (exu_done) begin
            gpr_wen <= (rd_addr != 5'd0);
            state   <= S_WB;
          end else if (exu_cnt == TIMEOUT_LAST) begin
            halt      <= 1'b1;
            halt_code <= HC_TIMEOUT;
            state     <= S_HALT;
          end else begin
            exu_cnt <= exu_cnt + 8'd1;
          end
        end

        S_WB: begin
          instret <= instret + 64'd1;
          if (next_pc[1:0] == 2'b00) begin
            pc        <= next_pc;
            req_valid <= 1'b1;
            state     <= S_FETCH;
          end else begin
            halt      <= 1'b1;
            halt_code <= HC_MISALGN;
            state     <= S_HALT;
          end
        end

        S_HALT: begin
        end

        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
